nexys_starship_spawn_ctrl: RTL and testbench
============================================

Name: nexys_starship_spawn_ctrl

Overview:
- Consumer of the four per-direction random spawn pulses (top/btm/left/right) produced by the PRNG.
- Turns each accepted pulse into a live monster slot with a countdown deadline, clears slots on player shots, keeps score, and declares game over when a deadline expires.
- Sits between the PRNG and the display/score logic in the game top level.

Parameters:
- TIMEOUT, 8'd50: timer_tick count a monster survives before game over.
- MAX_ACTIVE, 3: maximum simultaneous live monsters (1..4).
- SCORE_W, 8: score counter width.

Ports:
- Clk  input  1  system clock, all logic on posedge.
- Reset  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  one-cycle pulse; begins/restarts a game.
- timer_tick  input  1  one-cycle time-base strobe.
- top_random, btm_random, left_random, right_random  input  1 each  one-cycle spawn requests from PRNG.
- top_shot, btm_shot, left_shot, right_shot  input  1 each  one-cycle player shot pulses.
- top_monster, btm_monster, left_monster, right_monster  output  1 each  slot occupied (registered level).
- active_count  output  3  number of occupied slots (registered).
- score  output  SCORE_W  monsters destroyed this game.
- gameover  output  1  high while in OVER.
- playing  output  1  high while in PLAY.

Behaviour:
- Reset (Reset=0, async): state=IDLE; all *_monster=0, all timers=0, active_count=0, score=0, gameover=0, playing=0. Reset mid-game aborts immediately, with no expiry or score update.
- Game FSM:
  - IDLE → PLAY on start.
  - PLAY → OVER when any slot expires.
  - OVER → PLAY on start.
  - start while in PLAY restarts the game: all slots and score are cleared and the FSM stays in PLAY.
  - Entering PLAY clears all slots, timers and score in the same edge.
- Outside PLAY, spawn, shot and tick inputs are ignored. Slot contents freeze in OVER; slots stay clear in IDLE.
- Per-slot state is EMPTY or LIVE with timer[7:0].
- Spawn (PLAY, slot EMPTY, capacity available): at edge N the slot goes LIVE with timer=TIMEOUT; *_monster is visible high from cycle N+1. No decrement on the spawn cycle, even with timer_tick.
- Spawn on a LIVE slot is ignored; the timer is not reloaded.
- Capacity:
  - free = MAX_ACTIVE − active_count as registered at the start of the cycle. Kills in the same cycle do not free capacity.
  - Simultaneous requests are granted in fixed priority top > btm > left > right until free is exhausted. The rest are dropped, not queued.
- Shot on a LIVE slot: the slot goes EMPTY next edge and score += 1, saturating at all-ones.
- Multiple kills in one cycle add their count to score, still saturating.
- Shot on an EMPTY slot has no effect (miss).
- Shot and spawn on the same EMPTY slot in the same cycle: spawn wins, and the slot is LIVE with no kill.
- Shot and spawn on the same LIVE slot: kill; the slot ends EMPTY.
- Tick on a LIVE slot with timer>1: timer −= 1.
- Tick on a LIVE slot with timer==1: expiry, unless shot the same cycle (shot wins, counts as a kill).
- Expiry: next edge state=OVER, gameover=1, playing=0. The expiring slot remains LIVE (displayed). Kills of other slots in the same cycle still score.
- active_count is updated on the same edge as the slot changes; it always equals the popcount of the *_monster outputs.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset low mid-PLAY with 2 live slots and score=5 → all outputs 0 immediately, asynchronously, before the next Clk edge.
- start, then top_random pulse → top_monster=1 next cycle, active_count=1. After 50 timer_ticks with no shot → gameover=1, playing=0, top_monster stays 1.
- MAX_ACTIVE=3, all four *_random pulse in the same cycle → top, btm, left live, right_monster=0, active_count=3. A later right_random while 3 are live is dropped.
- LIVE top with timer=1, top_shot and timer_tick in the same cycle → top_monster=0, score=1, gameover=0.
- SCORE_W=2, score=3, kill two slots in one cycle → score stays 3. Shot on an EMPTY slot → score unchanged.
- In OVER with score=4, pulse start → playing=1, gameover=0, score=0, all slots clear next cycle.

Source files
------------

// File: rtl/nexys_starship_spawn_ctrl.sv
// Spawn/kill/expiry controller for the four monster slots. It turns PRNG spawn
// pulses into timed slots, scores player shots and ends the game on expiry.
module nexys_starship_spawn_ctrl #(
   parameter logic [7:0] TIMEOUT    = 8'd50,
   parameter int         MAX_ACTIVE = 3,
   parameter int         SCORE_W    = 8
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               start,
   input  logic               timer_tick,
   input  logic               top_random,
   input  logic               btm_random,
   input  logic               left_random,
   input  logic               right_random,
   input  logic               top_shot,
   input  logic               btm_shot,
   input  logic               left_shot,
   input  logic               right_shot,
   output logic               top_monster,
   output logic               btm_monster,
   output logic               left_monster,
   output logic               right_monster,
   output logic [2:0]         active_count,
   output logic [SCORE_W-1:0] score,
   output logic               gameover,
   output logic               playing
);

   // state | meaning
   // IDLE  | after reset, waiting for the first start; slots held clear
   // PLAY  | game running: spawns, shots and ticks are processed
   // OVER  | a deadline expired; slots frozen for display until start
   typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

   localparam logic [2:0]           MAX_C     = 3'(MAX_ACTIVE);
   localparam logic [SCORE_W+2:0]   SCORE_MAX = {3'b000, {SCORE_W{1'b1}}};

   state_t             state, state_nxt;
   logic [3:0]         live, live_nxt;
   logic [3:0][7:0]    timer, timer_nxt;
   logic [2:0]         count_nxt;
   logic [SCORE_W-1:0] score_nxt;
   logic [3:0]         spawn, shot, kill, expire;
   logic [2:0]         budget, kill_cnt;
   logic [SCORE_W+2:0] score_sum;

   // index order is the spawn priority: 0=top, 1=btm, 2=left, 3=right
   assign spawn = {right_random, left_random, btm_random, top_random};
   assign shot  = {right_shot, left_shot, btm_shot, top_shot};

   always_comb begin
      state_nxt = state;
      live_nxt  = live;
      timer_nxt = timer;
      score_nxt = score;
      kill      = '0;
      expire    = '0;
      kill_cnt  = '0;
      score_sum = '0;
      // capacity comes from the registered count, so same-cycle kills free nothing
      budget    = MAX_C - active_count;
      count_nxt = '0;

      case (state)
         IDLE, OVER: begin
            if (start) begin
               state_nxt = PLAY;
               live_nxt  = '0;
               timer_nxt = '0;
               score_nxt = '0;
            end
         end
         PLAY: begin
            if (start) begin
               live_nxt  = '0;
               timer_nxt = '0;
               score_nxt = '0;
            end else begin
               for (int i = 0; i < 4; i++) begin
                  if (live[i]) begin
                     if (shot[i]) begin
                        kill[i]      = 1'b1;
                        live_nxt[i]  = 1'b0;
                        timer_nxt[i] = '0;
                     end else if (timer_tick) begin
                        if (timer[i] == 8'd1) expire[i] = 1'b1;
                        else timer_nxt[i] = timer[i] - 8'd1;
                     end
                  end else if (spawn[i] && (budget != 3'd0)) begin
                     live_nxt[i]  = 1'b1;
                     timer_nxt[i] = TIMEOUT;
                     budget       = budget - 3'd1;
                  end
               end
               for (int i = 0; i < 4; i++)
                  kill_cnt = kill_cnt + {2'b00, kill[i]};
               score_sum = {3'b000, score} + (SCORE_W+3)'(kill_cnt);
               score_nxt = (score_sum > SCORE_MAX) ? {SCORE_W{1'b1}}
                                                   : score_sum[SCORE_W-1:0];
               if (|expire) state_nxt = OVER;
            end
         end
         default: state_nxt = IDLE;
      endcase

      for (int i = 0; i < 4; i++)
         count_nxt = count_nxt + {2'b00, live_nxt[i]};
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state        <= IDLE;
         live         <= '0;
         timer        <= '0;
         active_count <= '0;
         score        <= '0;
         gameover     <= 1'b0;
         playing      <= 1'b0;
      end else begin
         state        <= state_nxt;
         live         <= live_nxt;
         timer        <= timer_nxt;
         active_count <= count_nxt;
         score        <= score_nxt;
         gameover     <= (state_nxt == OVER);
         playing      <= (state_nxt == PLAY);
      end
   end

   assign top_monster   = live[0];
   assign btm_monster   = live[1];
   assign left_monster  = live[2];
   assign right_monster = live[3];

endmodule

// File: tb/tb_nexys_starship_spawn_ctrl.sv
// Directed bench for nexys_starship_spawn_ctrl; a second instance with a 2-bit
// score shares all inputs to exercise score saturation.
module tb_nexys_starship_spawn_ctrl;

   logic Clk, Reset, start, timer_tick;
   logic top_random, btm_random, left_random, right_random;
   logic top_shot, btm_shot, left_shot, right_shot;
   logic top_monster, btm_monster, left_monster, right_monster;
   logic [2:0] active_count;
   logic [7:0] score;
   logic gameover, playing;

   logic t2, b2, l2, r2, go2, pl2;
   logic [2:0] ac2;
   logic [1:0] score2;

   int n_checks = 0;
   int n_fail   = 0;

   nexys_starship_spawn_ctrl dut (
      .Clk(Clk), .Reset(Reset), .start(start), .timer_tick(timer_tick),
      .top_random(top_random), .btm_random(btm_random),
      .left_random(left_random), .right_random(right_random),
      .top_shot(top_shot), .btm_shot(btm_shot),
      .left_shot(left_shot), .right_shot(right_shot),
      .top_monster(top_monster), .btm_monster(btm_monster),
      .left_monster(left_monster), .right_monster(right_monster),
      .active_count(active_count), .score(score),
      .gameover(gameover), .playing(playing)
   );

   nexys_starship_spawn_ctrl #(.SCORE_W(2)) dut2 (
      .Clk(Clk), .Reset(Reset), .start(start), .timer_tick(timer_tick),
      .top_random(top_random), .btm_random(btm_random),
      .left_random(left_random), .right_random(right_random),
      .top_shot(top_shot), .btm_shot(btm_shot),
      .left_shot(left_shot), .right_shot(right_shot),
      .top_monster(t2), .btm_monster(b2),
      .left_monster(l2), .right_monster(r2),
      .active_count(ac2), .score(score2),
      .gameover(go2), .playing(pl2)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic clr_in();
      start = 0; timer_tick = 0;
      top_random = 0; btm_random = 0; left_random = 0; right_random = 0;
      top_shot = 0; btm_shot = 0; left_shot = 0; right_shot = 0;
   endtask

   function automatic logic [31:0] mons();
      return {28'd0, right_monster, left_monster, btm_monster, top_monster};
   endfunction

   initial begin
      Reset = 1'b1;
      clr_in();
      #2 Reset = 1'b0;
      #1;
      chk("rst_mons", mons(), 0);
      chk("rst_count", 32'(active_count), 0);
      chk("rst_score", 32'(score), 0);
      chk("rst_gameover", 32'(gameover), 0);
      chk("rst_playing", 32'(playing), 0);
      #9 Reset = 1'b1;

      // IDLE ignores spawns
      top_random = 1; cyc(); clr_in();
      chk("idle_spawn", mons(), 0);

      start = 1; cyc(); clr_in();
      chk("start_playing", 32'(playing), 1);
      chk("start_gameover", 32'(gameover), 0);

      top_random = 1; cyc(); clr_in();
      chk("spawn_top", mons(), 32'b0001);
      chk("spawn_count", 32'(active_count), 1);

      repeat (49) begin timer_tick = 1; cyc(); end
      clr_in();
      chk("tick49_playing", 32'(playing), 1);
      chk("tick49_gameover", 32'(gameover), 0);
      timer_tick = 1; cyc(); clr_in();
      chk("expire_gameover", 32'(gameover), 1);
      chk("expire_playing", 32'(playing), 0);
      chk("expire_mons", mons(), 32'b0001);
      chk("expire_count", 32'(active_count), 1);

      right_random = 1; top_shot = 1; timer_tick = 1; cyc(); clr_in();
      chk("over_frozen", mons(), 32'b0001);
      chk("over_score", 32'(score), 0);

      start = 1; cyc(); clr_in();
      chk("restart_playing", 32'(playing), 1);
      chk("restart_mons", mons(), 0);

      top_random = 1; btm_random = 1; left_random = 1; right_random = 1;
      cyc(); clr_in();
      chk("four_req_mons", mons(), 32'b0111);
      chk("four_req_count", 32'(active_count), 3);

      right_random = 1; cyc(); clr_in();
      chk("full_drop", mons(), 32'b0111);

      // kill in the same cycle does not free capacity
      top_shot = 1; right_random = 1; cyc(); clr_in();
      chk("kill_nofree_mons", mons(), 32'b0110);
      chk("kill_nofree_count", 32'(active_count), 2);
      chk("kill_score", 32'(score), 1);

      top_shot = 1; cyc(); clr_in();
      chk("miss_score", 32'(score), 1);

      top_random = 1; top_shot = 1; cyc(); clr_in();
      chk("spawn_beats_shot", mons(), 32'b0111);
      chk("spawn_beats_shot_score", 32'(score), 1);

      start = 1; cyc(); clr_in();
      chk("restart2_score", 32'(score), 0);
      chk("restart2_mons", mons(), 0);

      top_random = 1; cyc(); clr_in();
      repeat (49) begin timer_tick = 1; cyc(); end
      top_shot = 1; timer_tick = 1; cyc(); clr_in();
      chk("race_mons", mons(), 0);
      chk("race_score", 32'(score), 1);
      chk("race_gameover", 32'(gameover), 0);
      chk("race_playing", 32'(playing), 1);

      top_random = 1; btm_random = 1; left_random = 1; cyc(); clr_in();
      top_shot = 1; btm_shot = 1; cyc(); clr_in();
      chk("dbl_kill_score", 32'(score), 3);
      chk("dbl_kill_score2", 32'(score2), 3);
      chk("dbl_kill_mons", mons(), 32'b0100);

      top_random = 1; btm_random = 1; cyc(); clr_in();
      chk("refill_mons", mons(), 32'b0111);
      top_shot = 1; btm_shot = 1; cyc(); clr_in();
      chk("dbl_kill2_score", 32'(score), 5);
      chk("sat_score2", 32'(score2), 3);

      right_shot = 1; cyc(); clr_in();
      chk("miss2_score", 32'(score), 5);
      chk("miss2_score2", 32'(score2), 3);

      // left has been live since its spawn with no ticks yet
      repeat (50) begin timer_tick = 1; cyc(); end
      clr_in();
      chk("over2_gameover", 32'(gameover), 1);
      chk("over2_mons", mons(), 32'b0100);
      chk("over2_score", 32'(score), 5);

      start = 1; cyc(); clr_in();
      chk("over_restart_playing", 32'(playing), 1);
      chk("over_restart_gameover", 32'(gameover), 0);
      chk("over_restart_score", 32'(score), 0);
      chk("over_restart_mons", mons(), 0);
      chk("over_restart_count", 32'(active_count), 0);

      top_random = 1; btm_random = 1; left_random = 1; cyc(); clr_in();
      left_shot = 1; cyc(); clr_in();
      chk("pre_rst_mons", mons(), 32'b0011);
      chk("pre_rst_score", 32'(score), 1);

      #2 Reset = 1'b0;
      #1;
      chk("async_rst_mons", mons(), 0);
      chk("async_rst_count", 32'(active_count), 0);
      chk("async_rst_score", 32'(score), 0);
      chk("async_rst_playing", 32'(playing), 0);
      chk("async_rst_gameover", 32'(gameover), 0);
      #2 Reset = 1'b1;

      top_random = 1; cyc(); clr_in();
      chk("post_rst_idle", mons(), 0);
      chk("post_rst_playing", 32'(playing), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
